// File: rtl/display_port_if.sv
// Processor-to-display write port bundle: write strobe/data with ready, plus the
// saturated display value, its overflow flag and the reload pulse.
interface display_port_if;
  logic               wr_en;
  logic signed [15:0] wr_data;
  logic               wr_ready;
  logic signed [13:0] disp_value;
  logic               ovf;
  logic               upd;

  // Processor side drives the write, observes readiness and the display.
  modport master (
    output wr_en, wr_data,
    input  wr_ready, disp_value, ovf, upd
  );

  // Display port side.
  modport slave (
    input  wr_en, wr_data,
    output wr_ready, disp_value, ovf, upd
  );
endinterface

// File: rtl/display_port.sv
// Rate-limited, saturating output port between a processor and a signed 14-bit
// display input. Every committed value is held for at least HOLD_CYCLES cycles.
// A single write arriving during the hold waits in a one-entry pending slot.
// Values are clamped to +/-8191, so -8192 is never presented downstream.
module display_port #(
  parameter int unsigned HOLD_CYCLES = 50000
) (
  input logic           clk,
  input logic           rst_n,
  display_port_if.slave bus
);

  localparam int unsigned CW = 20;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic signed [15:0] SAT_MAX = 16'sd8191;
  localparam logic signed [15:0] SAT_MIN = -16'sd8191;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [13:0] val;
  } sat_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_pend_valid;
  logic signed [15:0] r_pend_data;
  logic signed [13:0] r_disp;
  logic               r_ovf;
  logic               r_upd;

  logic               w_ready;
  logic               w_accept;
  logic               w_commit;
  logic signed [15:0] w_commit_data;
  sat_t               w_sat;

  // Clamp to the symmetric range; the asymmetric -8192 is folded to -8191.
  function automatic sat_t saturate(input logic signed [15:0] d);
    sat_t s;
    if (d > SAT_MAX) begin
      s.ovf = 1'b1;
      s.val = 14'sd8191;
    end else if (d < SAT_MIN) begin
      s.ovf = 1'b1;
      s.val = -14'sd8191;
    end else begin
      s.ovf = 1'b0;
      s.val = d[13:0];
    end
    return s;
  endfunction

  // The slot is always empty in IDLE, so readiness depends only on the slot.
  assign w_ready  = ~r_pend_valid;
  assign w_accept = bus.wr_en & w_ready;
  assign w_sat    = saturate(w_commit_data);

  // Decide whether a commit happens this cycle and which value it takes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_commit      = 1'b0;
    w_commit_data = bus.wr_data;
    case (r_state)
      IDLE: w_commit = w_accept;
      HOLD: begin
        if (r_cnt == '0) begin
          if (r_pend_valid) begin
            w_commit      = 1'b1;
            w_commit_data = r_pend_data;
          end else begin
            w_commit = w_accept;
          end
        end
      end
      default: w_commit = 1'b0;
    endcase
  end

  // Hold FSM with registered display outputs and the pending slot.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      // NOTE: the slot data is cleared too; it is a single register, so reset
      // is cheap and keeps a discarded write from lingering anywhere.
      r_pend_data  <= '0;
      r_disp       <= '0;
      r_ovf        <= 1'b0;
      r_upd        <= 1'b0;
    end else begin
      r_upd <= w_commit;
      if (w_commit) begin
        r_disp <= w_sat.val;
        r_ovf  <= w_sat.ovf;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= RELOAD;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_accept) begin
              r_pend_valid <= 1'b1;
              r_pend_data  <= bus.wr_data;
            end
          end else if (r_pend_valid) begin
            r_pend_valid <= 1'b0;
            r_cnt        <= RELOAD;
          end else if (w_accept) begin
            r_cnt <= RELOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready   = w_ready;
  assign bus.disp_value = r_disp;
  assign bus.ovf        = r_ovf;
  assign bus.upd        = r_upd;

endmodule

// File: doc/display_port.md
DISPLAY_PORT -- requirements
Module: display_port

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 50000: minimum clock cycles a committed value is held on disp_value before the next commit; legal range 1..2^20.
REQ-002 SHALL provide input clk, 1 bit: single system clock; all state changes on the rising edge.
REQ-003 SHALL provide input rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide input wr_en, 1 bit: processor write strobe; a write is accepted when wr_en and wr_ready are both 1 on a rising edge.
REQ-005 SHALL provide input wr_data, 16 bits signed: processor output-port value.
REQ-006 SHALL provide output wr_ready, 1 bit: the port can accept a write this cycle.
REQ-007 SHALL provide output disp_value, 14 bits signed: saturated value feeding the signed 14-bit input of the display interface.
REQ-008 SHALL provide output ovf, 1 bit: the currently displayed value was saturated.
REQ-009 SHALL provide output upd, 1 bit: single-cycle pulse in the cycle after disp_value is reloaded.

Function
REQ-010 SHALL implement two states: IDLE (no hold active) and HOLD (hold counter running).
REQ-011 SHALL saturate every committed value to [-8191, +8191]: wr_data > 8191 gives 8191; wr_data < -8191 (including -32768) gives -8191; otherwise pass unchanged. ovf = 1 if and only if clamping occurred.
REQ-012 SHALL never drive -8192 on disp_value, so the downstream magnitude conversion cannot overflow.
REQ-013 SHALL hold wr_ready = 1 in IDLE, and in HOLD while the pending slot is empty.
REQ-014 In IDLE, an accepted write SHALL:
  - update disp_value, ovf and upd at the next rising edge (1-cycle latency);
  - load the hold counter with HOLD_CYCLES-1;
  - enter HOLD.
REQ-015 In HOLD with counter > 0:
  - the counter SHALL decrement by 1 per cycle;
  - an accepted write SHALL be stored, unsaturated, in a one-entry pending slot;
  - wr_ready SHALL then drop to 0 until the slot drains.
REQ-016 In HOLD with counter = 0 and the pending slot full:
  - the slot SHALL be committed (saturated) to disp_value/ovf with upd = 1 on the next cycle;
  - the slot SHALL be cleared and the counter reloaded to HOLD_CYCLES-1;
  - the block SHALL remain in HOLD.
REQ-017 In HOLD with counter = 0, slot empty and an accepted write in the same cycle: wr_data SHALL be committed directly (bypass), the counter reloaded, and the block SHALL remain in HOLD.
REQ-018 In HOLD with counter = 0, slot empty and no write: the block SHALL return to IDLE, and disp_value SHALL remain unchanged.
REQ-019 With HOLD_CYCLES = 1, consecutive commits SHALL be possible on every cycle, and wr_ready SHALL never deassert.
REQ-020 upd SHALL be 0 in every cycle not directly following a commit.
REQ-021 disp_value and ovf SHALL change only on a commit and hold their values otherwise, including across IDLE.
REQ-022 A write not accepted (wr_en = 1, wr_ready = 0) SHALL be ignored and SHALL NOT disturb the pending slot.

Reset
REQ-023 While rst_n = 0:
  - state = IDLE; disp_value = 0; ovf = 0; upd = 0; wr_ready = 1;
  - hold counter = 0; pending slot empty.
REQ-024 Reset assertion mid-HOLD SHALL discard any pending write immediately, without waiting for a clock edge.
REQ-025 The first rising edge after rst_n deasserts SHALL be able to accept a write.

Verification (HOLD_CYCLES = 4 unless stated)
REQ-026 Reset, then write 1234 in IDLE -> disp_value = 1234, ovf = 0, upd = 1 one cycle later; wr_ready stays 1.
REQ-027 Write 12000, then after hold expiry write -32768 -> disp_value 8191 with ovf = 1, then -8191 with ovf = 1; write -8191 -> ovf = 0.
REQ-028 Write 10, then writes 20 and 30 on the next two cycles -> 20 accepted to the slot, wr_ready = 0, 30 ignored; disp_value = 20 exactly 4 cycles after the 10 commit; 30 is never displayed.
REQ-029 Write 5, then a write of 7 exactly at counter = 0 with the slot empty -> 7 displayed 4 cycles after 5 via bypass; state remains HOLD for another 4 cycles, then IDLE.
REQ-030 Write 100, then write 200 to the slot, then assert rst_n = 0 mid-hold -> disp_value = 0, ovf = 0, wr_ready = 1 immediately; 200 never appears.
REQ-031 HOLD_CYCLES = 1, write on every cycle with values 1, 2, 3 -> disp_value shows 1, 2, 3 on consecutive cycles, upd = 1 on each, wr_ready always 1.
